wb_stage: RTL
=============

Name: wb_stage

Overview:
- Parametrised writeback stage for the pipelined core.
- Contains the MEM/WB pipeline register with valid, stall and flush control.
- Selects the result from a 4-way source mux and sign- or zero-extends sub-word loads.
- Drives the register-file write port and the W-stage forwarding bus; an optional retired-instruction counter can be compiled in.

Parameters:
- DATA_WIDTH, 32, datapath width; must be 32 or 64.
- REG_ADDR_W, 5, register index width.
- COUNT_W, 64, retire counter width (used only with the optional feature).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- StallW  in  1  hold the W-stage register.
- FlushW  in  1  insert a bubble into the W stage.
- ValidM  in  1  M-stage slot holds a real instruction.
- RegWriteM  in  1  instruction writes rd.
- ResultSrcM  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 immediate (LUI).
- Funct3M  in  3  load size/sign encoding.
- ALUResultM  in  DATA_WIDTH  ALU result; also the load address.
- ReadDataM  in  DATA_WIDTH  raw memory read word.
- PCPlus4M  in  DATA_WIDTH  PC+4.
- ImmExtM  in  DATA_WIDTH  extended immediate.
- RdM  in  REG_ADDR_W  destination register.
- ValidW  out  1  W slot valid.
- RegWriteWout  out  1  register-file write enable.
- ResultWout  out  DATA_WIDTH  writeback data; also the forwarding value.
- RdWout  out  REG_ADDR_W  destination register.
- RetireCount  out  COUNT_W  retired instructions (present only with the optional feature).

Behaviour:
- Capture: on each rising edge, all M-stage inputs are captured into W registers. Priority is rst > FlushW > StallW > capture.
- Reset: every W register clears to 0, so ValidW=0, RegWriteWout=0, RdWout=0 and ResultWout=0 (ALU source, zero data). RetireCount=0.
- Flush: ValidW<=0 and RegWriteW<=0; the data registers may keep any value.
- Flush and stall together: the flush wins.
- Stall: all W registers hold their values, and the outputs are held stable.
- Latency: one cycle from the M inputs to the W outputs. ResultWout is combinational from the W registers, with no extra cycle.
- Write enable: RegWriteWout = ValidW & RegWriteW & (RdW != 0). Writes to x0 are suppressed, and ResultWout is still driven.
- Load extraction (ResultSrc=01), byte offset = ALUResultW[1:0]:
  - LB (000) selects byte[offset] and sign-extends it.
  - LBU (100) selects byte[offset] and zero-extends it.
  - LH (001) selects halfword[offset[1]] and sign-extends it.
  - LHU (101) selects halfword[offset[1]] and zero-extends it.
  - LW (010) uses bits [31:0], sign-extended when DATA_WIDTH=64.
  - Any other funct3 passes the raw word through.
  - Misaligned halfwords use offset[1] only; offset[0] is ignored.
- Result mux: 00 ALU, 01 extracted load, 10 PCPlus4, 11 Imm. All four codes are defined, with no latch and no don't-care.
- Stall while W is valid: the register file sees the same write each cycle, which is idempotent.

Optional Feature:
- Macro: WB_RETIRE_CNT_EN.
- With the macro defined:
  - RetireCount increments by 1 on each edge where ValidW=1 and StallW=0 and rst=0.
  - It wraps from all-ones to 0.
  - A flush does not decrement it.
- Without the macro: the RetireCount port and its counter are absent, with no dead logic.

Decomposition:
- Package wb_pkg holds:
  - enum result_src_e: RES_ALU=2'b00, RES_LOAD=2'b01, RES_PC4=2'b10, RES_IMM=2'b11.
  - enum load_f3_e: LB, LH, LW, LBU, LHU.
  - typedef wb_bundle_t: struct of the captured M-stage fields.
- Sub-module load_extend (purely combinational):
  - inputs: raw word, offset, funct3.
  - output: the extended value.
- wb_stage instantiates load_extend once.

Test Plan:
- Reset: rst=1 for 2 cycles with arbitrary inputs → ValidW=0, RegWriteWout=0, RdWout=0, ResultWout=0, RetireCount=0.
- Basic paths (ValidM=1, RegWriteM=1, RdM=5):
  - ResultSrc=00, ALU=0x1234 → next cycle ResultWout=0x1234, RegWriteWout=1, RdWout=5.
  - ResultSrc=10, PC+4=0x88 → ResultWout=0x88.
  - ResultSrc=11, Imm=0xABCD0000 → ResultWout=0xABCD0000.
- Loads, ReadData=0x80FF7F01:
  - LB, addr[1:0]=3 → 0xFFFFFF80.
  - LBU, addr[1:0]=3 → 0x00000080.
  - LH, addr[1:0]=2 → 0xFFFF80FF.
  - LHU, addr[1:0]=0 → 0x00007F01.
  - LW → 0x80FF7F01.
- x0 suppression: RdM=0, RegWriteM=1 → RegWriteWout=0 while ResultWout still shows the data.
- Stall and flush:
  - Instruction A captured, then StallW=1 for 3 cycles while M changes → outputs stay A.
  - FlushW=1 together with StallW=1 → ValidW=0, RegWriteWout=0 on the next cycle.
- Counter (WB_RETIRE_CNT_EN):
  - 10 valid instructions, 2 flushed and 3 stall cycles → RetireCount=8.
  - Preload near all-ones (COUNT_W=4 instance), one more retirement → wraps to 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: result-source and load-size encodings
// plus the captured control bundle of the MEM/WB pipeline register.
package wb_pkg;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_IMM  = 2'b11
    } result_src_e;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_f3_e;

    // Width-independent control fields; the datapath fields live beside it
    // because a package struct cannot follow DATA_WIDTH.
    typedef struct packed {
        logic        valid;
        logic        regWrite;
        result_src_e resultSrc;
        logic [2:0]  funct3;
    } wb_bundle_t;

endpackage

// File: rtl/load_extend.sv
// Combinational sub-word load extraction: picks a byte/halfword/word out of the
// raw memory word by address offset and sign- or zero-extends it.
module load_extend
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_raw,
    input  logic [1:0]            i_offset,
    input  logic [2:0]            i_funct3,
    output logic [DATA_WIDTH-1:0] o_ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_raw[7:0];
        case (i_offset)
            2'd0: w_byte = i_raw[7:0];
            2'd1: w_byte = i_raw[15:8];
            2'd2: w_byte = i_raw[23:16];
            2'd3: w_byte = i_raw[31:24];
        endcase
    end

    // Halfword selection ignores offset[0]; misaligned halves are not trapped here.
    assign w_half = i_offset[1] ? i_raw[31:16] : i_raw[15:0];

    always_comb begin
        o_ext = i_raw;
        case (i_funct3)
            LB:      o_ext = DATA_WIDTH'($signed(w_byte));
            LBU:     o_ext = DATA_WIDTH'(w_byte);
            LH:      o_ext = DATA_WIDTH'($signed(w_half));
            LHU:     o_ext = DATA_WIDTH'(w_half);
            LW:      o_ext = DATA_WIDTH'($signed(i_raw[31:0]));
            default: o_ext = i_raw;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register with flush/stall, result mux, load extension.
// Define WB_RETIRE_CNT_EN to build in the RetireCount retired-instruction counter.
module wb_stage
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5,
    parameter int COUNT_W    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StallW,
    input  logic                  FlushW,
    input  logic                  ValidM,
    input  logic                  RegWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic [2:0]            Funct3M,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] ReadDataM,
    input  logic [DATA_WIDTH-1:0] PCPlus4M,
    input  logic [DATA_WIDTH-1:0] ImmExtM,
    input  logic [REG_ADDR_W-1:0] RdM,
    output logic                  ValidW,
    output logic                  RegWriteWout,
    output logic [DATA_WIDTH-1:0] ResultWout,
    output logic [REG_ADDR_W-1:0] RdWout
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [COUNT_W-1:0]    RetireCount
`endif
);

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_badDataWidth
        $error("wb_stage: DATA_WIDTH must be 32 or 64");
    end
    if (COUNT_W < 1) begin : g_badCountWidth
        $error("wb_stage: COUNT_W must be at least 1");
    end

    wb_bundle_t            r_ctrl;
    logic [DATA_WIDTH-1:0] r_alu;
    logic [DATA_WIDTH-1:0] r_readData;
    logic [DATA_WIDTH-1:0] r_pc4;
    logic [DATA_WIDTH-1:0] r_imm;
    logic [REG_ADDR_W-1:0] r_rd;

    logic [DATA_WIDTH-1:0] w_loadData;
    logic [DATA_WIDTH-1:0] w_result;
    logic                  w_rdNonZero;

    // Flush only needs to kill the control bits; stale data is harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl     <= '0;
            r_alu      <= '0;
            r_readData <= '0;
            r_pc4      <= '0;
            r_imm      <= '0;
            r_rd       <= '0;
        end else if (FlushW) begin
            r_ctrl.valid    <= 1'b0;
            r_ctrl.regWrite <= 1'b0;
        end else if (!StallW) begin
            r_ctrl.valid     <= ValidM;
            r_ctrl.regWrite  <= RegWriteM;
            r_ctrl.resultSrc <= result_src_e'(ResultSrcM);
            r_ctrl.funct3    <= Funct3M;
            r_alu            <= ALUResultM;
            r_readData       <= ReadDataM;
            r_pc4            <= PCPlus4M;
            r_imm            <= ImmExtM;
            r_rd             <= RdM;
        end
    end

    load_extend #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_loadExtend (
        .i_raw   (r_readData),
        .i_offset(r_alu[1:0]),
        .i_funct3(r_ctrl.funct3),
        .o_ext   (w_loadData)
    );

    always_comb begin
        w_result = r_alu;
        case (r_ctrl.resultSrc)
            RES_ALU:  w_result = r_alu;
            RES_LOAD: w_result = w_loadData;
            RES_PC4:  w_result = r_pc4;
            RES_IMM:  w_result = r_imm;
        endcase
    end

    // x0 is hardwired to zero, so its writes are dropped but the data still forwards.
    assign w_rdNonZero  = (r_rd != '0);
    assign ValidW       = r_ctrl.valid;
    assign RegWriteWout = r_ctrl.valid & r_ctrl.regWrite & w_rdNonZero;
    assign ResultWout   = w_result;
    assign RdWout       = r_rd;

`ifdef WB_RETIRE_CNT_EN
    logic [COUNT_W-1:0] r_retireCount;

    // The W instruction retires whenever it leaves the stage, flush or not.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_retireCount <= '0;
        end else if (r_ctrl.valid && !StallW) begin
            r_retireCount <= r_retireCount + COUNT_W'(1);
        end
    end

    assign RetireCount = r_retireCount;
`endif

endmodule
